parity_frame_rx: RTL and testbench
==================================

# parity_frame_rx

Serial receiver that deserializes start/data/parity/stop frames from a single-bit line and presents a parallel data nibble plus its received parity bit on a valid/ready output. It sits directly upstream of the even-parity checker stage. Its `out_data`/`out_p` pair drives the checker's `in`/`p` inputs, and the checker judges parity. The block itself handles only framing, buffering and overrun.

## Interface
- `DATA_W`, default 4: number of data bits per frame, sent LSB first.
- `clk`, input, 1: system clock, rising edge.
- `rst_n`, input, 1: asynchronous reset, active-low.
- `bit_en`, input, 1: sample strobe, one `clk` cycle wide per bit period. `rx` is sampled only when it is high.
- `rx`, input, 1: serial line, idle high.
- `out_data`, output, `DATA_W`: received data bits, bit 0 = first data bit received.
- `out_p`, output, 1: received parity bit.
- `out_valid`, output, 1: the output holding register is full.
- `out_ready`, input, 1: consumer accepts the frame on a cycle where `out_valid && out_ready`.
- `frame_err`, output, 1: one-cycle pulse when the stop bit is sampled low.
- `overrun`, output, 1: one-cycle pulse when a good frame is dropped because the holding register is full.

## Operation
- **FSM states:** IDLE, DATA, PARITY, STOP. All transitions occur only on cycles with `bit_en=1`. State holds otherwise.
- **IDLE:**
  - `rx=0` moves to DATA (start bit) and clears the bit counter.
  - `rx=1` stays in IDLE.
- **DATA:**
  - Shifts `rx` into the shift register LSB first.
  - Bit counter counts 0..`DATA_W`-1.
  - After sampling bit `DATA_W`-1, moves to PARITY.
- **PARITY:** captures `rx` as the parity bit, then moves to STOP.
- **STOP with `rx=1` (good frame):**
  - If the holding register is empty, or is being drained this same cycle (`out_valid && out_ready`), load the shift data and parity into `out_data`/`out_p` and set `out_valid`.
  - Otherwise drop the frame, pulse `overrun`, and leave `out_data`/`out_p`/`out_valid` unchanged.
- **STOP with `rx=0`:** pulse `frame_err` and discard the frame. The holding register is untouched.
- From STOP, always return to IDLE. A low line in the next `bit_en` cycle is treated as a new start bit.
- **Output handshake:**
  - `out_valid` clears on `out_valid && out_ready` unless a new frame loads in the same cycle, in which case `out_valid` stays 1 with the new contents.
  - `out_data`/`out_p` are stable while `out_valid=1 && out_ready=0`.
- **Counter width:** the bit counter is `$clog2(DATA_W)` bits wide (minimum 1). No wrap-around occurs because DATA exits at count `DATA_W`-1.
- **Parity:** the block performs no parity evaluation unless the feature in Configuration is compiled in.

## Timing
- **Reset values:**
  - State IDLE; counter 0; shift register 0.
  - `out_data=0`, `out_p=0`, `out_valid=0`, `frame_err=0`, `overrun=0`.
- **Reset assertion:** `rst_n` low at any time, including mid-frame, clears everything immediately (asynchronous). A partial frame is lost. After release, reception resumes from IDLE.
- **Frame length:** `DATA_W`+3 `bit_en` samples (start, data, parity, stop).
- **Latency:** `out_valid`, `frame_err` and `overrun` are registered. Each is seen high in the cycle after the `clk` edge on which the stop bit is sampled.
- **Pulse width:** `frame_err` and `overrun` are high for exactly one `clk` cycle, independent of `bit_en` spacing.
- **Back-to-back `bit_en`:** `bit_en` on every cycle is legal, giving one bit per clock.
- **`out_ready`:** may toggle freely and has no combinational path to any output.

## Configuration
- **Macro `PARITY_FRAME_RX_CHECK_EN`:**
  - When defined, adds output port `parity_err` (1 bit, reset 0).
  - `parity_err` is loaded together with `out_data`/`out_p` as the XOR of all data bits and the parity bit. 1 means the even-parity check failed.
  - It follows the same hold and handshake rules as `out_data`.
- **Without the macro:** the port and its logic are absent, and the downstream checker is the sole parity judge.

## Test plan
1. **Single good frame.**
   - Stimulus: reset, then `bit_en` every cycle; `rx` sequence 0 | 0,1,0,1 | 0 | 1; `out_ready=1`.
   - Required: `out_data=4'b1010`, `out_p=0`, `out_valid` high one cycle. With the macro, `parity_err=0`.
2. **Parity mismatch passed through.**
   - Stimulus: data 4'b0001 with parity bit 0.
   - Required: `out_data=4'b0001`, `out_p=0`. With the macro, `parity_err=1`. Without it, no error indication.
3. **Framing error.**
   - Stimulus: frame with data 4'b1110, parity 1, stop bit 0.
   - Required: `frame_err` one-cycle pulse, `out_valid` stays 0. A following good frame (data 4'b1001, p=0) is received correctly.
4. **Backpressure and overrun.**
   - Stimulus: `out_ready=0`; send 4'b1010/p0, then 4'b0011/p0.
   - Required: `out_data` holds 4'b1010 and one `overrun` pulse occurs. Raising `out_ready` then empties the register.
5. **Simultaneous drain and load.**
   - Stimulus: `out_ready` pulses high on the exact cycle the second frame's stop bit is sampled.
   - Required: no `overrun`; `out_valid` stays 1 with the new data.
6. **Reset mid-frame and sparse strobe.**
   - Stimulus: drop `rst_n` during the DATA state.
   - Required: all outputs 0 immediately. The next full frame, sent with `bit_en` every 4th cycle, is received correctly.

Source files
------------

// File: rtl/parity_frame_rx_if.sv
// -----------------------------------------------------------------------------
// parity_frame_rx_if
//   Bundles the serial input side and the parallel valid/ready output side of
//   parity_frame_rx.
//
//   Signals:
//     bit_en     - sample strobe, one clk wide per bit period
//     rx         - serial line, idle high
//     out_data   - received data bits, bit 0 = first data bit on the line
//     out_p      - received parity bit
//     out_valid  - output holding register full
//     out_ready  - consumer accepts on out_valid && out_ready
//     frame_err  - one-cycle pulse, stop bit sampled low
//     overrun    - one-cycle pulse, good frame dropped (holding register full)
//     parity_err - only with PARITY_FRAME_RX_CHECK_EN: XOR of data and parity
//
//   Modports:
//     slave  - the receiver (consumes the line, produces the frame)
//     master - the environment (drives the line, consumes the frame)
// -----------------------------------------------------------------------------
interface parity_frame_rx_if #(
   parameter int DATA_W = 4
);
   logic              bit_en;
   logic              rx;
   logic [DATA_W-1:0] out_data;
   logic              out_p;
   logic              out_valid;
   logic              out_ready;
   logic              frame_err;
   logic              overrun;
`ifdef PARITY_FRAME_RX_CHECK_EN
   logic              parity_err;
`endif

   modport slave (
      input  bit_en, rx, out_ready,
      output out_data, out_p, out_valid, frame_err, overrun
`ifdef PARITY_FRAME_RX_CHECK_EN
      , output parity_err
`endif
   );

   modport master (
      output bit_en, rx, out_ready,
      input  out_data, out_p, out_valid, frame_err, overrun
`ifdef PARITY_FRAME_RX_CHECK_EN
      , input parity_err
`endif
   );
endinterface : parity_frame_rx_if

// File: rtl/parity_frame_rx.sv
// -----------------------------------------------------------------------------
// parity_frame_rx
//   Deserializes start / DATA_W data (LSB first) / parity / stop frames from a
//   single-bit line and offers the data nibble plus its received parity bit on
//   a one-deep valid/ready holding register. Framing, buffering and overrun
//   only; parity is judged downstream unless the check feature is compiled in.
//
//   Ports:
//     clk    - system clock, rising edge
//     rst_n  - asynchronous reset, active low
//     bus    - parity_frame_rx_if.slave (bit_en, rx, out_ready in;
//              out_data, out_p, out_valid, frame_err, overrun out)
//
//   Optional feature (macro PARITY_FRAME_RX_CHECK_EN):
//     adds bus.parity_err = ^data ^ parity, loaded and held with out_data.
// -----------------------------------------------------------------------------
module parity_frame_rx #(
   parameter int DATA_W = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   parity_frame_rx_if.slave       bus
);

   localparam int                CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0]  LAST  = CNT_W'(DATA_W - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t            state_q,  state_d;
   logic [CNT_W-1:0]  cnt_q,    cnt_d;
   logic [DATA_W-1:0] shift_q,  shift_d;
   logic              par_q,    par_d;
   logic [DATA_W-1:0] data_q,   data_d;
   logic              p_q,      p_d;
   logic              valid_q,  valid_d;
   logic              ferr_q,   ferr_d;
   logic              ovr_q,    ovr_d;
`ifdef PARITY_FRAME_RX_CHECK_EN
   logic              perr_q,   perr_d;
`endif

   // NOTE: every register is reset here, so outputs read 0 immediately on
   // rst_n low, even in the middle of a frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
         data_q  <= '0;
         p_q     <= 1'b0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         ovr_q   <= 1'b0;
`ifdef PARITY_FRAME_RX_CHECK_EN
         perr_q  <= 1'b0;
`endif
      end else begin
         // NOTE: non-blocking so every register samples the pre-edge values.
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         data_q  <= data_d;
         p_q     <= p_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
         ovr_q   <= ovr_d;
`ifdef PARITY_FRAME_RX_CHECK_EN
         perr_q  <= perr_d;
`endif
      end
   end

   always_comb begin
      // NOTE: hold-by-default first, so no path through the case infers a latch.
      state_d = state_q;
      cnt_d   = cnt_q;
      shift_d = shift_q;
      par_d   = par_q;
      data_d  = data_q;
      p_d     = p_q;
      valid_d = valid_q;
      ferr_d  = 1'b0;
      ovr_d   = 1'b0;
`ifdef PARITY_FRAME_RX_CHECK_EN
      perr_d  = perr_q;
`endif

      // Drain first; a load in the same cycle below overrides this.
      if (valid_q && bus.out_ready) begin
         valid_d = 1'b0;
      end

      if (bus.bit_en) begin
         unique case (state_q)
            S_IDLE: begin
               if (!bus.rx) begin
                  state_d = S_DATA;
                  cnt_d   = '0;
               end
            end
            S_DATA: begin
               // Bit k lands in position k: LSB-first without a shift chain.
               shift_d[cnt_q] = bus.rx;
               if (cnt_q == LAST) begin
                  state_d = S_PARITY;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            S_PARITY: begin
               par_d   = bus.rx;
               state_d = S_STOP;
            end
            S_STOP: begin
               state_d = S_IDLE;
               if (bus.rx) begin
                  // Free, or freed by a drain on this very edge.
                  if (!valid_q || bus.out_ready) begin
                     data_d  = shift_q;
                     p_d     = par_q;
                     valid_d = 1'b1;
`ifdef PARITY_FRAME_RX_CHECK_EN
                     perr_d  = (^shift_q) ^ par_q;
`endif
                  end else begin
                     ovr_d = 1'b1;
                  end
               end else begin
                  ferr_d = 1'b1;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   assign bus.out_data  = data_q;
   assign bus.out_p     = p_q;
   assign bus.out_valid = valid_q;
   assign bus.frame_err = ferr_q;
   assign bus.overrun   = ovr_q;
`ifdef PARITY_FRAME_RX_CHECK_EN
   assign bus.parity_err = perr_q;
`endif

endmodule : parity_frame_rx

// File: tb/tb_parity_frame_rx.sv
// -----------------------------------------------------------------------------
// tb_parity_frame_rx
//   Scoreboard bench for parity_frame_rx (DATA_W = 4). Frames expected to be
//   delivered are queued when sent; a negedge monitor pops and compares on
//   every accepted handshake and counts frame_err / overrun / out_valid cycles.
// -----------------------------------------------------------------------------
module tb_parity_frame_rx;

   localparam int DATA_W = 4;

   typedef struct {
      logic [DATA_W-1:0] data;
      logic              p;
      logic              perr;
   } exp_t;

   logic clk;
   logic rst_n;

   int checks   = 0;
   int failures = 0;
   int ferr_cnt  = 0;
   int ovr_cnt   = 0;
   int valid_cnt = 0;

   exp_t sb_q[$];

   parity_frame_rx_if #(.DATA_W(DATA_W)) bus ();

   parity_frame_rx #(.DATA_W(DATA_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: inputs change just after posedge, so at negedge a valid&&ready
   // pair is exactly what the next posedge will accept.
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.frame_err) ferr_cnt++;
         if (bus.overrun)   ovr_cnt++;
         if (bus.out_valid) valid_cnt++;
         if (bus.out_valid && bus.out_ready) begin
            exp_t e;
            checks++;
            if (sb_q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_frame: got data=%b p=%b, required none",
                        bus.out_data, bus.out_p);
            end else begin
               e = sb_q.pop_front();
               if (bus.out_data !== e.data || bus.out_p !== e.p) begin
                  failures++;
                  $display("FAIL frame_content: got data=%b p=%b, required data=%b p=%b",
                           bus.out_data, bus.out_p, e.data, e.p);
               end
`ifdef PARITY_FRAME_RX_CHECK_EN
               checks++;
               if (bus.parity_err !== e.perr) begin
                  failures++;
                  $display("FAIL parity_err: got %b, required %b", bus.parity_err, e.perr);
               end
`endif
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b, input int gap);
      bus.bit_en = 1'b1;
      bus.rx     = b;
      tick();
      bus.bit_en = 1'b0;
      bus.rx     = 1'b1;
      repeat (gap) tick();
   endtask

   // Sends one frame; pushes its expectation when it should be delivered.
   // ready_at_stop raises out_ready only for the stop-bit sampling cycle.
   task automatic send_frame(input logic [DATA_W-1:0] data, input logic p,
                             input logic stop, input int gap, input bit push,
                             input bit ready_at_stop);
      exp_t e;
      if (push) begin
         e.data = data;
         e.p    = p;
         e.perr = (^data) ^ p;
         sb_q.push_back(e);
      end
      send_bit(1'b0, gap);
      for (int i = 0; i < DATA_W; i++) send_bit(data[i], gap);
      send_bit(p, gap);
      if (ready_at_stop) bus.out_ready = 1'b1;
      send_bit(stop, 0);
      if (ready_at_stop) bus.out_ready = 1'b0;
      repeat (gap) tick();
   endtask

   task automatic wait_drain(input string name);
      for (int i = 0; i < 40; i++) begin
         if (sb_q.size() == 0) break;
         tick();
      end
      tick();
      checks++;
      if (sb_q.size() != 0) begin
         failures++;
         $display("FAIL %s_drain: %0d frames still pending, required 0", name, sb_q.size());
         sb_q.delete();
      end
   endtask

   task automatic expect_int(input string name, input int got, input int req);
      checks++;
      if (got !== req) begin
         failures++;
         $display("FAIL %s: got %0d, required %0d", name, got, req);
      end
   endtask

   task automatic test_reset();
      rst_n         = 1'b0;
      bus.bit_en    = 1'b0;
      bus.rx        = 1'b1;
      bus.out_ready = 1'b0;
      repeat (2) tick();
      checks++;
      if ({bus.out_data, bus.out_p, bus.out_valid, bus.frame_err, bus.overrun} !== '0) begin
         failures++;
         $display("FAIL reset_outputs: got data=%b p=%b v=%b fe=%b ov=%b, required all 0",
                  bus.out_data, bus.out_p, bus.out_valid, bus.frame_err, bus.overrun);
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_single_frame();
      int v0 = valid_cnt;
      bus.out_ready = 1'b1;
      send_frame(4'b1010, 1'b0, 1'b1, 0, 1'b1, 1'b0);
      wait_drain("single");
      expect_int("single_valid_cycles", valid_cnt - v0, 1);
   endtask

   task automatic test_parity_mismatch();
      int f0 = ferr_cnt;
      int o0 = ovr_cnt;
      bus.out_ready = 1'b1;
      send_frame(4'b0001, 1'b0, 1'b1, 0, 1'b1, 1'b0);
      wait_drain("mismatch");
      expect_int("mismatch_no_frame_err", ferr_cnt - f0, 0);
      expect_int("mismatch_no_overrun", ovr_cnt - o0, 0);
   endtask

   task automatic test_frame_err();
      int f0 = ferr_cnt;
      int v0 = valid_cnt;
      bus.out_ready = 1'b1;
      send_frame(4'b1110, 1'b1, 1'b0, 0, 1'b0, 1'b0);
      repeat (3) tick();
      expect_int("frame_err_pulses", ferr_cnt - f0, 1);
      expect_int("frame_err_valid_cycles", valid_cnt - v0, 0);
      send_frame(4'b1001, 1'b0, 1'b1, 0, 1'b1, 1'b0);
      wait_drain("after_frame_err");
   endtask

   task automatic test_overrun();
      int o0 = ovr_cnt;
      bus.out_ready = 1'b0;
      send_frame(4'b1010, 1'b0, 1'b1, 0, 1'b1, 1'b0);
      send_frame(4'b0011, 1'b0, 1'b1, 0, 1'b0, 1'b0);
      repeat (3) tick();
      expect_int("overrun_pulses", ovr_cnt - o0, 1);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 4'b1010) begin
         failures++;
         $display("FAIL overrun_hold: got v=%b data=%b, required v=1 data=1010",
                  bus.out_valid, bus.out_data);
      end
      bus.out_ready = 1'b1;
      wait_drain("overrun");
      expect_int("overrun_emptied", int'(bus.out_valid), 0);
   endtask

   task automatic test_back_to_back();
      int o0 = ovr_cnt;
      bus.out_ready = 1'b0;
      send_frame(4'b0110, 1'b0, 1'b1, 0, 1'b1, 1'b0);
      send_frame(4'b1101, 1'b1, 1'b1, 0, 1'b1, 1'b1);
      tick();
      expect_int("simul_no_overrun", ovr_cnt - o0, 0);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 4'b1101 || bus.out_p !== 1'b1) begin
         failures++;
         $display("FAIL simul_reload: got v=%b data=%b p=%b, required v=1 data=1101 p=1",
                  bus.out_valid, bus.out_data, bus.out_p);
      end
      bus.out_ready = 1'b1;
      wait_drain("simul");
   endtask

   task automatic test_reset_midframe();
      bus.out_ready = 1'b0;
      send_frame(4'b0101, 1'b0, 1'b1, 0, 1'b0, 1'b0);
      expect_int("pre_reset_valid", int'(bus.out_valid), 1);
      send_bit(1'b0, 0);
      send_bit(1'b1, 0);
      send_bit(1'b1, 0);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({bus.out_data, bus.out_p, bus.out_valid, bus.frame_err, bus.overrun} !== '0) begin
         failures++;
         $display("FAIL midframe_reset: got data=%b p=%b v=%b fe=%b ov=%b, required all 0",
                  bus.out_data, bus.out_p, bus.out_valid, bus.frame_err, bus.overrun);
      end
      #3 rst_n = 1'b1;
      tick();
      bus.out_ready = 1'b1;
      send_frame(4'b1011, 1'b1, 1'b1, 3, 1'b1, 1'b0);
      wait_drain("sparse");
      send_frame(4'b0100, 1'b0, 1'b1, 3, 1'b1, 1'b0);
      wait_drain("sparse2");
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_parity_mismatch();
      test_frame_err();
      test_overrun();
      test_back_to_back();
      test_reset_midframe();
      expect_int("final_scoreboard_empty", sb_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_parity_frame_rx
